// File: rtl/axi_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axi_chan_fifo
// Brief    : Registered valid/ready buffer for one AXI4 channel, reporting fill
//            level and an almost-full flag. Define AXI_CHAN_FIFO_PROTO_CHK_EN
//            to enable the sticky upstream protocol checker (proto_err).
// Revision : 1.0 - initial release
// ============================================================================
module axi_chan_fifo #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AFULL_TH = 3
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_W-1:0]            s_payload,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_W-1:0]            m_payload,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         afull,
    output logic                         proto_err
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_LVL_W = $clog2(DEPTH + 1);
    localparam logic [c_LVL_W-1:0] c_DEPTH_L = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0] c_AFULL_L = c_LVL_W'(AFULL_TH);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_LVL_W-1:0] level_q;
    logic [c_LVL_W-1:0] level_d;
    logic               afull_q;
    logic               w_push;
    logic               w_pop;

    // Ready depends only on registered state so there is no s->m combinational path.
    assign s_ready   = ~areset & (level_q != c_DEPTH_L);
    assign m_valid   = (level_q != '0);
    assign w_push    = s_valid & s_ready;
    assign w_pop     = m_valid & m_ready;
    assign m_payload = m_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign afull     = afull_q;

    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            afull_q <= (level_d >= c_AFULL_L);
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= s_payload;
        end
    end

`ifdef AXI_CHAN_FIFO_PROTO_CHK_EN
    logic              prev_valid_q;
    logic              prev_ready_q;
    logic [DATA_W-1:0] prev_payload_q;
    logic              proto_err_q;
    logic              w_violation;

    // A stalled beat must stay valid and stable until accepted.
    assign w_violation = prev_valid_q & ~prev_ready_q &
                         (~s_valid | (s_payload != prev_payload_q));

    always_ff @(posedge aclk) begin
        if (areset) begin
            prev_valid_q   <= 1'b0;
            prev_ready_q   <= 1'b0;
            prev_payload_q <= '0;
            proto_err_q    <= 1'b0;
        end else begin
            prev_valid_q   <= s_valid;
            prev_ready_q   <= s_ready;
            prev_payload_q <= s_payload;
            proto_err_q    <= proto_err_q | w_violation;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_chan_fifo.sv
`default_nettype none
// Testbench for axi_chan_fifo: directed scenarios plus a queue scoreboard
// that follows every handshake and checks output order and status flags.
module tb_axi_chan_fifo;

    localparam int DATA_W   = 64;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;
    localparam int LVL_W    = $clog2(DEPTH + 1);

    logic              aclk = 1'b0;
    logic              areset;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_payload;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_payload;
    logic [LVL_W-1:0]  level;
    logic              afull;
    logic              proto_err;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb_q[$];

    axi_chan_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_payload (s_payload),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_payload (m_payload),
        .level     (level),
        .afull     (afull),
        .proto_err (proto_err)
    );

    always #5 aclk = ~aclk;

    // Scoreboard: predicts handshakes from its own occupancy, then checks the DUT.
    always @(negedge aclk) begin
        logic [DATA_W-1:0] exp_data;
        logic exp_ready;
        logic exp_valid;
        if (areset) begin
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL sb_ready_in_reset: got %b want 0", s_ready);
            end
            sb_q.delete();
        end else begin
            exp_ready = (sb_q.size() != DEPTH);
            exp_valid = (sb_q.size() != 0);
            checks++;
            if (level !== LVL_W'(sb_q.size())) begin
                errors++;
                $display("FAIL sb_level: got %0d want %0d", level, sb_q.size());
            end
            checks++;
            if (s_ready !== exp_ready) begin
                errors++;
                $display("FAIL sb_s_ready: got %b want %b", s_ready, exp_ready);
            end
            checks++;
            if (m_valid !== exp_valid) begin
                errors++;
                $display("FAIL sb_m_valid: got %b want %b", m_valid, exp_valid);
            end
            checks++;
            if (afull !== (sb_q.size() >= AFULL_TH)) begin
                errors++;
                $display("FAIL sb_afull: got %b want %b", afull, sb_q.size() >= AFULL_TH);
            end
            if (exp_valid) begin
                if (m_ready) begin
                    exp_data = sb_q.pop_front();
                    checks++;
                    if (m_payload !== exp_data) begin
                        errors++;
                        $display("FAIL sb_pop_data: got %h want %h", m_payload, exp_data);
                    end
                end
            end else begin
                checks++;
                if (m_payload !== '0) begin
                    errors++;
                    $display("FAIL sb_empty_payload: got %h want 0", m_payload);
                end
            end
            if (s_valid && exp_ready) sb_q.push_back(s_payload);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_payload = '0;
        tick(); tick();
        checks++;
        if (m_valid !== 1'b0 || level !== '0 || afull !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b l=%0d af=%b pe=%b want 0/0/0/0",
                     m_valid, level, afull, proto_err);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_s_ready: got %b want 0", s_ready);
        end
        areset = 1'b0;
        tick();
    endtask

    task automatic test_basic_order();
        logic [DATA_W-1:0] vals[3] = '{64'hA1, 64'hA2, 64'hA3};
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_payload = vals[i];
            tick();
        end
        s_valid = 1'b0;
        checks++;
        if (level !== 3'd3 || afull !== 1'b1 || m_payload !== 64'hA1) begin
            errors++;
            $display("FAIL basic_fill: got l=%0d af=%b p=%h want 3/1/a1", level, afull, m_payload);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_payload !== vals[i]) begin
                errors++;
                $display("FAIL basic_pop_order: got %h want %h", m_payload, vals[i]);
            end
            tick();
        end
        m_ready = 1'b0;
        checks++;
        if (level !== '0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got l=%0d v=%b want 0/0", level, m_valid);
        end
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_payload = 64'hB0 + 64'(i);
            tick();
        end
        s_payload = 64'hB4;
        checks++;
        if (s_ready !== 1'b0 || level !== 3'd4) begin
            errors++;
            $display("FAIL stall_full: got r=%b l=%0d want 0/4", s_ready, level);
        end
        tick();
        checks++;
        if (level !== 3'd4 || m_payload !== 64'hB0) begin
            errors++;
            $display("FAIL stall_hold: got l=%0d p=%h want 4/b0", level, m_payload);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || level !== 3'd3) begin
            errors++;
            $display("FAIL stall_reopen: got r=%b l=%0d want 1/3", s_ready, level);
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL stall_fifth: got l=%0d want 4", level);
        end
        m_ready = 1'b1;
        repeat (4) tick();
        m_ready = 1'b0;
    endtask

    task automatic test_streaming_wrap();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_payload = 64'(i);
            tick();
            checks++;
            if (level !== 3'd1 || m_payload !== 64'(i)) begin
                errors++;
                $display("FAIL stream_beat%0d: got l=%0d p=%h want 1/%h", i, level, m_payload, i);
            end
        end
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        checks++;
        if (level !== '0) begin
            errors++;
            $display("FAIL stream_end: got l=%0d want 0", level);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_payload = 64'hC0 + 64'(i);
            tick();
        end
        s_payload = 64'hC4;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (level !== 3'd3 || m_payload !== 64'hC1) begin
            errors++;
            $display("FAIL simul_pop: got l=%0d p=%h want 3/c1", level, m_payload);
        end
        tick();
        s_valid = 1'b0;
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL simul_push: got l=%0d want 4", level);
        end
        m_ready = 1'b1;
        repeat (4) tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_payload = 64'hD0 + 64'(i);
            tick();
        end
        s_valid = 1'b0;
        areset = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b want 0", s_ready);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0 || level !== '0 || afull !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got v=%b l=%0d af=%b want 0/0/0", m_valid, level, afull);
        end
        areset = 1'b0;
        s_valid = 1'b1; s_payload = 64'h55;
        tick();
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_payload !== 64'h55) begin
            errors++;
            $display("FAIL rst_mid_push: got v=%b p=%h want 1/55", m_valid, m_payload);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_proto();
        logic exp_err;
`ifdef AXI_CHAN_FIFO_PROTO_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_payload = 64'hE0 + 64'(i);
            tick();
        end
        s_payload = 64'h10;
        tick();
        s_payload = 64'h11;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_early: got %b want 0", proto_err);
        end
        tick();
        checks++;
        if (proto_err !== exp_err) begin
            errors++;
            $display("FAIL proto_set: got %b want %b", proto_err, exp_err);
        end
        s_valid = 1'b0;
        tick(); tick();
        checks++;
        if (proto_err !== exp_err) begin
            errors++;
            $display("FAIL proto_sticky: got %b want %b", proto_err, exp_err);
        end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_clear: got %b want 0", proto_err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_fill_stall();
        test_streaming_wrap();
        test_full_simul();
        test_reset_mid();
        test_proto();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
